ram_cmd_sequencer: RTL and testbench

//  Upstream driver for ram_async (32x32, combinational read, level write on writeOn).

---
 rtl/ram_cmd_sequencer_pkg.sv | 27 ++
 rtl/ram_cmd_sequencer_if.sv | 25 ++
 rtl/ram_cmd_sequencer_fifo.sv | 48 ++++
 rtl/ram_cmd_sequencer.sv | 118 +++++++++++
 tb/tb_ram_cmd_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_cmd_sequencer_pkg.sv
// Shared types and constants for the RAM command sequencer.
// The command is packed as {addr, wr, data}; offsets below assume the default widths.
package ram_seq_pkg;

    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_DATA_W   = 32;
    localparam int CMD_W        = DEF_ADDR_W + 1 + DEF_DATA_W;
    localparam int CMD_WR_BIT   = DEF_DATA_W;
    localparam int CMD_ADDR_LSB = DEF_DATA_W + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        WPULSE = 3'd2,
        WHOLD  = 3'd3,
        RWAIT  = 3'd4,
        RESP   = 3'd5
    } state_t;

    // The phase timer counts 0..N-1, so it needs clog2 of the longer phase (min 1 bit).
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ram_cmd_sequencer_if.sv
// Command and response handshake bundle between an upstream client and the sequencer.
interface ram_cmd_sequencer_if
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_W+DATA_W:0]   cmd_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_data;
    logic [ADDR_W-1:0]        rsp_addr;

    modport master (
        output cmd_valid, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr
    );
endinterface

// File: rtl/ram_cmd_sequencer_fifo.sv
// Registered command FIFO; output is the head entry, never fall-through.
module cmd_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ram_cmd_sequencer.sv
// Replays buffered {addr, wr, data} commands onto an async RAM with safe setup/hold
// around a registered write pulse, and returns read data over a valid/ready port.
module ram_cmd_sequencer
    import ram_seq_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_PULSE   = 2,
    parameter int RD_WAIT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_cmd_sequencer_if.slave    bus,
    output logic [ADDR_W-1:0]     ram_address,
    output logic                  ram_writeOn,
    output logic [DATA_W-1:0]     ram_data_in,
    input  logic [DATA_W-1:0]     ram_data_out,
    output logic                  busy
);
    localparam int CW       = ADDR_W + 1 + DATA_W;
    localparam int WR_BIT   = DATA_W;
    localparam int ADDR_LSB = DATA_W + 1;
    localparam int TW       = tmr_width(WR_PULSE, RD_WAIT);

    logic              push, pop, full, empty;
    logic [CW-1:0]     head;
    state_t            state, state_nxt;
    logic [TW-1:0]     tmr;
    logic              pulse_done, rd_done, capture, rsp_clr, wr_on_nxt;
    logic              hold_wr, wr_on_q, rsp_valid_q;
    logic [ADDR_W-1:0] hold_addr, rsp_addr_q;
    logic [DATA_W-1:0] hold_data, rsp_data_q;

    // Gating with rst keeps the client from pushing while the FIFO is held in reset.
    assign bus.cmd_ready = ~full & ~rst;
    assign push          = bus.cmd_valid & bus.cmd_ready;

    cmd_fifo #(.WIDTH(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.cmd_data),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign pulse_done = (tmr == TW'(WR_PULSE - 1));
    assign rd_done    = (tmr == TW'(RD_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= (state_nxt != state) ? '0 : tmr + TW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty)       state_nxt = SETUP;
            SETUP:   state_nxt = hold_wr ? WPULSE : RWAIT;
            WPULSE:  if (pulse_done)   state_nxt = WHOLD;
            WHOLD:   state_nxt = IDLE;
            RWAIT:   if (rd_done)      state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && !empty;
        capture   = (state == RWAIT) && rd_done;
        rsp_clr   = (state == RESP) && bus.rsp_ready;
        wr_on_nxt = (state_nxt == WPULSE);
        busy      = (state != IDLE) || !empty;
    end

    // writeOn comes straight from a flop so the RAM never sees a decode glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_wr     <= 1'b0;
            hold_addr   <= '0;
            hold_data   <= '0;
            wr_on_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            wr_on_q <= wr_on_nxt;
            if (pop) begin
                hold_wr   <= head[WR_BIT];
                hold_addr <= head[CW-1:ADDR_LSB];
                hold_data <= head[DATA_W-1:0];
            end
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_addr_q  <= hold_addr;
                rsp_data_q  <= ram_data_out;
            end else if (rsp_clr) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign ram_address   = hold_addr;
    assign ram_data_in   = hold_data;
    assign ram_writeOn   = wr_on_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_ram_cmd_sequencer.sv
// Scoreboard bench: a behavioural RAM image predicts every write pulse and read response.
module tb_ram_cmd_sequencer;
    import ram_seq_pkg::*;

    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int WRP = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_cmd_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    logic [AW-1:0] ram_address;
    logic          ram_writeOn;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic          busy;

    ram_cmd_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4), .WR_PULSE(WRP), .RD_WAIT(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .ram_address  (ram_address),
        .ram_writeOn  (ram_writeOn),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out),
        .busy         (busy)
    );

    // Stand-in for ram_async: combinational read, level-sensitive write.
    logic [DW-1:0] ram_mem [32];
    initial for (int i = 0; i < 32; i++) ram_mem[i] = '0;
    always @(ram_writeOn or ram_address or ram_data_in)
        if (ram_writeOn) ram_mem[ram_address] = ram_data_in;
    assign ram_data_out = ram_mem[ram_address];

    logic [DW-1:0] mdl_mem [32];
    bit            known [32];
    exp_t          rsp_q[$];
    exp_t          wr_q[$];
    int            checks = 0;
    int            errors = 0;
    bit            rand_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {a, w, d};
        while (!bus.cmd_ready && t < 200) begin
            tick();
            t++;
        end
        if (!bus.cmd_ready) begin
            check("push_timeout", 64'd0, 64'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        if (w) begin
            mdl_mem[a] = d;
            known[a]   = 1'b1;
            wr_q.push_back('{addr: a, data: d, chk: 1'b1});
        end else begin
            rsp_q.push_back('{addr: a, data: mdl_mem[a], chk: known[a]});
        end
        tick();
    endtask

    task automatic drain();
        int t = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0 || busy) && t < 500) begin
            tick();
            t++;
        end
        check("drain_timeout", 64'(t >= 500), 64'd0);
    endtask

    // Response monitor: sampled mid-low-phase, after the driver's negedge updates.
    exp_t          re;
    bit            prev_hold = 0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold && bus.rsp_valid) begin
                check("rsp_stable_data", bus.rsp_data, prev_data);
                check("rsp_stable_addr", bus.rsp_addr, prev_addr);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    re = rsp_q.pop_front();
                    check("rsp_addr", bus.rsp_addr, re.addr);
                    if (re.chk) check("rsp_data", bus.rsp_data, re.data);
                end
            end
            prev_hold = bus.rsp_valid && !bus.rsp_ready;
            prev_data = bus.rsp_data;
            prev_addr = bus.rsp_addr;
        end
    end

    // Write monitor: each pulse must match the next expected write and last WRP cycles.
    exp_t we;
    bit   in_pulse = 0;
    int   wlen = 0;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            in_pulse = 0;
            wlen     = 0;
        end else if (ram_writeOn) begin
            if (!in_pulse) begin
                in_pulse = 1;
                wlen     = 0;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 64'd1, 64'd0);
                    we = '0;
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", ram_address, we.addr);
                    check("wr_data", ram_data_in, we.data);
                end
            end else begin
                check("wr_addr_stable", ram_address, we.addr);
            end
            wlen++;
        end else if (in_pulse) begin
            check("wr_pulse_len", 64'(wlen), 64'(WRP));
            in_pulse = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    bit            exp_wo [5] = '{0, 1, 1, 0, 0};
    bit            exp_bz [5] = '{1, 1, 1, 1, 0};
    bit            wo [5];
    bit            bz [5];
    bit            rv_seen;
    logic [DW-1:0] t4_exp;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mdl_mem[i] = '0;
            known[i]   = 1'b1;
        end
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", bus.cmd_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_writeOn", ram_writeOn, 0);
        check("rst_busy", busy, 0);
        check("rst_address", ram_address, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;
        #1;
        check("rel_cmd_ready", bus.cmd_ready, 1);
        tick();

        // 1: single write, pulse timing and busy window
        push(5'd3, 1'b1, 32'hDEADBEEF);
        bus.cmd_valid = 1'b0;
        rv_seen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            wo[k] = ram_writeOn;
            bz[k] = busy;
            rv_seen |= bus.rsp_valid;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t1_writeOn_n%0d", k + 1), 64'(wo[k]), 64'(exp_wo[k]));
            check($sformatf("t1_busy_n%0d", k + 1), 64'(bz[k]), 64'(exp_bz[k]));
        end
        check("t1_no_rsp", 64'(rv_seen), 64'd0);

        // 2: read back, response latency
        push(5'd3, 1'b0, 32'h0);
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check("t2_rsp_valid_n2", bus.rsp_valid, 0);
        tick();
        check("t2_rsp_valid_n3", bus.rsp_valid, 1);
        drain();

        // 3: address extremes
        push(5'd31, 1'b1, 32'hA5A5A5A5);
        push(5'd0,  1'b1, 32'h5A5A5A5A);
        push(5'd31, 1'b0, 32'h0);
        push(5'd0,  1'b0, 32'h0);
        bus.cmd_valid = 1'b0;
        drain();

        // 4: response backpressure fills the FIFO
        bus.rsp_ready = 1'b0;
        t4_exp = mdl_mem[31];
        push(5'd31, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) push(AW'(10 + i), 1'b1, $urandom);
        bus.cmd_data = {5'd14, 1'b1, 32'h14141414};
        for (int i = 0; i < 4; i++) begin
            check("t4_cmd_ready_full", bus.cmd_ready, 0);
            check("t4_rsp_valid_hold", bus.rsp_valid, 1);
            check("t4_rsp_data_hold", bus.rsp_data, t4_exp);
            tick();
        end
        bus.rsp_ready = 1'b1;
        push(5'd14, 1'b1, 32'h14141414);
        push(5'd12, 1'b0, 32'h0);
        push(5'd14, 1'b0, 32'h0);
        bus.cmd_valid = 1'b0;
        drain();

        // 5: reset in the middle of a write pulse
        push(5'd9, 1'b1, 32'h12345678);
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        check("t5_writeOn_before", ram_writeOn, 1);
        #1;
        rst = 1'b1;
        rsp_q.delete();
        wr_q.delete();
        known[9] = 1'b0;
        #1;
        check("t5_writeOn_async", ram_writeOn, 0);
        check("t5_cmd_ready_rst", bus.cmd_ready, 0);
        tick();
        tick();
        check("t5_busy_rst", busy, 0);
        rst = 1'b0;
        #1;
        check("t5_busy_rel", busy, 0);
        check("t5_cmd_ready_rel", bus.cmd_ready, 1);
        tick();
        push(5'd9, 1'b0, 32'h0);
        push(5'd3, 1'b0, 32'h0);
        bus.cmd_valid = 1'b0;
        drain();

        // 6: back-to-back mixed stream
        push(5'd20, 1'b1, 32'h20202020);
        push(5'd21, 1'b1, 32'h21212121);
        push(5'd20, 1'b0, 32'h0);
        push(5'd22, 1'b1, 32'h22222222);
        push(5'd21, 1'b0, 32'h0);
        bus.cmd_valid = 1'b0;
        drain();

        // Random traffic with random response backpressure
        rand_rdy = 1;
        for (int i = 0; i < 80; i++) begin
            push(AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                bus.cmd_valid = 1'b0;
                tick();
            end
        end
        bus.cmd_valid = 1'b0;
        rand_rdy = 0;
        bus.rsp_ready = 1'b1;
        drain();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
